edge_grad: RTL and testbench
============================

# edge_grad

Streaming gradient-magnitude edge detector for raster video: the parametrised successor to the team's fixed 8-bit edge stage. It takes one pixel per qualified clock, keeps one line of history in an internal circular line buffer, and forms horizontal and vertical absolute differences. It then combines them by a runtime-selectable mode and emits the result with frame/line markers delayed to match. It sits between the pixel source/decimator and the Hough accumulator front end.

## Interface
Parameters:
- DW, 8, pixel width in bits (in and out).
- MAXW, 320, maximum line width in pixels; sets line-buffer depth.
- WW, 9, width of the Width port; must satisfy 2^WW > MAXW.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- nReset  in  1  synchronous, active-low reset, sampled on the Clk rising edge.
- PixelIn  in  DW  input pixel, unsigned.
- ValidIn  in  1  qualifies PixelIn/FrameIn/LineIn; all inputs are ignored when low.
- FrameIn  in  1  marks the first pixel of a frame; implies the start of a line.
- LineIn  in  1  marks the first pixel of a line.
- Width  in  WW  active line width; sampled only on a FrameIn pixel.
- Mode  in  1  0 = mean, (h+v)>>1; 1 = max(h,v); sampled every valid pixel.
- Thresh  in  DW  binarisation threshold; present only with EDGE_THRESH_EN.
- PixelOut  out  DW  gradient magnitude.
- ValidOut  out  1  PixelOut/FrameOut/LineOut are valid.
- FrameOut  out  1  FrameIn delayed to align with PixelOut.
- LineOut  out  1  LineIn, or FrameIn, delayed to align with PixelOut.

## Operation
- Column counter `col`:
  - set to 0 on a valid pixel carrying LineIn or FrameIn;
  - otherwise increments on each valid pixel;
  - saturates at min(Width,MAXW)-1, so extra pixels overwrite the last buffer entry.
- Row state:
  - FrameIn sets the first-row flag.
  - The next LineIn without FrameIn clears it.
- Width latch:
  - loaded on a FrameIn pixel;
  - value 0 is treated as 1;
  - values above MAXW are clamped to MAXW.
- Line buffer: MAXW x DW entries.
  - On each valid pixel, read entry [col] (the pixel above) and write PixelIn to [col] in the same cycle.
  - Read returns the old data (read-before-write).
  - The buffer is not reset.
- Left neighbour: a register holding the previous valid pixel.
- Gradients, each DW bits and unsigned, with no overflow possible:
  - h = |P - left|, forced to 0 when col = 0;
  - v = |P - above|, forced to 0 on the first row.
- Combine:
  - Mode 0: out = (h+v)>>1, with the sum computed at DW+1 bits.
  - Mode 1: out = max(h,v).
- FrameIn or LineIn mid-line restarts the column at 0. The partial line still in the buffer becomes the "above" line for the columns it covered.
- Invalid cycles do not advance `col` or the buffer. ValidOut goes low and PixelOut holds its last value.

## Timing
- Fixed latency of 3 cycles from valid input to output:
  - S1: register pixel, left, above and markers.
  - S2: register h, v.
  - S3: combine and drive outputs.
- Throughput is one pixel per clock, with no backpressure.
- FrameOut and LineOut are high only in cycles where ValidOut is high.
- Reset (nReset low at an edge):
  - PixelOut = 0, ValidOut = 0, FrameOut = 0, LineOut = 0;
  - col = 0, first-row flag = 1, Width latch = MAXW;
  - all pipeline valid bits cleared.
- Reset asserted mid-frame discards in-flight pixels. The first output after release appears 3 cycles after the first valid input.
- Mode changes take effect on the pixel sampled in the same cycle; Mode is pipelined with the data.

## Configuration
- EDGE_THRESH_EN defined:
  - the Thresh port exists;
  - S3 outputs all-ones (2^DW-1) when the combined value is >= Thresh, else 0;
  - latency is unchanged.
- EDGE_THRESH_EN undefined: no Thresh port; PixelOut carries the raw combined magnitude.

## Test plan
- Reset: hold nReset low 2 cycles mid-stream -> all outputs 0. With ValidIn continuous after release, ValidOut first rises 3 cycles after the first valid pixel.
- Flat frame, Width=4, all pixels 100, Mode 0 -> 16 outputs, all 0. FrameOut on output 1; LineOut on outputs 1, 5, 9, 13.
- Step, Width=4, DW=8, Mode 0, row0 = 0,0,200,200 and row1 = 0,0,200,200:
  - row0 out = 0,0,100,0;
  - row1 out = 0,0,100,0 (v = 0 everywhere).
- Vertical step, Width=3, row0 = 10,10,10 and row1 = 250,250,250:
  - Mode 1 row1 out = 240,240,240;
  - Mode 0 row1 out = 120,120,120.
- Gaps: the step case repeated with ValidIn low every other cycle -> identical output sequence. ValidOut low in gap cycles; PixelOut holds.
- EDGE_THRESH_EN with Thresh=100, vertical step case, Mode 1 -> row1 out 255,255,255 and row0 out 0,0,0. With Thresh=241 -> all 0.

Source files
------------

// File: rtl/edge_grad.sv
// edge_grad: streaming gradient-magnitude edge detector.
// One pixel per qualified clock, one line of history in a circular line
// buffer, horizontal/vertical absolute differences combined by Mode,
// three-stage pipeline with frame/line markers carried alongside.
// Optional build macro EDGE_THRESH_EN adds the Thresh port and binarises
// the combined magnitude to all-ones / zero.
module edge_grad #(
  parameter int DW   = 8,
  parameter int MAXW = 320,
  parameter int WW   = 9
) (
  input  logic          Clk,
  input  logic          nReset,
  input  logic [DW-1:0] PixelIn,
  input  logic          ValidIn,
  input  logic          FrameIn,
  input  logic          LineIn,
  input  logic [WW-1:0] Width,
  input  logic          Mode,
`ifdef EDGE_THRESH_EN
  input  logic [DW-1:0] Thresh,
`endif
  output logic [DW-1:0] PixelOut,
  output logic          ValidOut,
  output logic          FrameOut,
  output logic          LineOut
);

  localparam int AW = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [WW-1:0] MAXW_W = WW'(MAXW);
  localparam logic [WW-1:0] ONE_W  = WW'(1);

  logic [DW-1:0] line_buf [MAXW];

  logic [WW-1:0] col_q, width_q;
  logic          first_q;

  logic [WW-1:0] width_in, width_cur, pix_col, col_inc, col_nxt;
  logic [AW-1:0] buf_idx;
  logic          first_cur;

  logic          s1_vld, s1_hz, s1_vz, s1_frame, s1_line, s1_mode;
  logic [DW-1:0] pix_s1, left_s1, above_s1;
  logic [DW-1:0] h_s1, v_s1;

  logic          s2_vld, s2_frame, s2_line, s2_mode;
  logic [DW-1:0] h_s2, v_s2;
  logic [DW:0]   sum_s2;
  logic [DW-1:0] comb_s2, res_s2;

  // Column, row and width bookkeeping for the pixel currently presented.
  // A frame pixel uses the width it carries so saturation is right from
  // the very first pixel of the frame.
  always_comb begin
    width_in = Width;
    if (Width == '0)
      width_in = ONE_W;
    else if (Width > MAXW_W)
      width_in = MAXW_W;
    width_cur = FrameIn ? width_in : width_q;
    pix_col   = (FrameIn || LineIn) ? '0 : col_q;
    col_inc   = pix_col + ONE_W;
    col_nxt   = (col_inc >= width_cur) ? pix_col : col_inc;
    buf_idx   = pix_col[AW-1:0];
    first_cur = FrameIn ? 1'b1 : (LineIn ? 1'b0 : first_q);
  end

  // Tracking registers advance only on valid pixels.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      col_q   <= '0;
      first_q <= 1'b1;
      width_q <= MAXW_W;
    end else if (ValidIn) begin
      col_q   <= col_nxt;
      first_q <= first_cur;
      if (FrameIn)
        width_q <= width_in;
    end
  end

  // Line buffer read-before-write plus S1 data capture; no reset needed.
  always_ff @(posedge Clk) begin
    if (nReset && ValidIn) begin
      above_s1          <= line_buf[buf_idx];
      line_buf[buf_idx] <= PixelIn;
      pix_s1            <= PixelIn;
      left_s1           <= pix_s1;
    end
  end

  // S1 control: valid, gradient-forcing flags, markers and mode.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      s1_vld   <= 1'b0;
      s1_hz    <= 1'b1;
      s1_vz    <= 1'b1;
      s1_frame <= 1'b0;
      s1_line  <= 1'b0;
      s1_mode  <= 1'b0;
    end else begin
      s1_vld <= ValidIn;
      if (ValidIn) begin
        s1_hz    <= (pix_col == '0);
        s1_vz    <= first_cur;
        s1_frame <= FrameIn;
        s1_line  <= FrameIn | LineIn;
        s1_mode  <= Mode;
      end
    end
  end

  // Absolute differences, forced to zero at column 0 / on the first row.
  always_comb begin
    h_s1 = '0;
    v_s1 = '0;
    if (!s1_hz)
      h_s1 = (pix_s1 > left_s1) ? pix_s1 - left_s1 : left_s1 - pix_s1;
    if (!s1_vz)
      v_s1 = (pix_s1 > above_s1) ? pix_s1 - above_s1 : above_s1 - pix_s1;
  end

  // S2: register gradients with their markers and mode.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      s2_vld   <= 1'b0;
      s2_frame <= 1'b0;
      s2_line  <= 1'b0;
      s2_mode  <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        h_s2     <= h_s1;
        v_s2     <= v_s1;
        s2_frame <= s1_frame;
        s2_line  <= s1_line;
        s2_mode  <= s1_mode;
      end
    end
  end

  // Combine: mean uses a DW+1 bit sum so the halving never overflows.
  always_comb begin
    sum_s2  = {1'b0, h_s2} + {1'b0, v_s2};
    comb_s2 = s2_mode ? ((h_s2 > v_s2) ? h_s2 : v_s2) : sum_s2[DW:1];
`ifdef EDGE_THRESH_EN
    res_s2  = (comb_s2 >= Thresh) ? '1 : '0;
`else
    res_s2  = comb_s2;
`endif
  end

  // S3: drive outputs; PixelOut holds across invalid cycles.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      PixelOut <= '0;
      ValidOut <= 1'b0;
      FrameOut <= 1'b0;
      LineOut  <= 1'b0;
    end else begin
      ValidOut <= s2_vld;
      FrameOut <= s2_vld & s2_frame;
      LineOut  <= s2_vld & s2_line;
      if (s2_vld)
        PixelOut <= res_s2;
    end
  end

endmodule

// File: tb/tb_edge_grad.sv
// tb_edge_grad: directed and randomized checks of edge_grad against an
// image-level reference model (row/column arithmetic on integers).
module tb_edge_grad;

  localparam int DW   = 8;
  localparam int MAXW = 320;
  localparam int WW   = 9;

  logic          Clk = 1'b0;
  logic          nReset;
  logic [DW-1:0] PixelIn;
  logic          ValidIn, FrameIn, LineIn, Mode;
  logic [WW-1:0] Width;
  logic [DW-1:0] PixelOut;
  logic          ValidOut, FrameOut, LineOut;
`ifdef EDGE_THRESH_EN
  logic [DW-1:0] Thresh;
`endif

  int checks = 0;
  int errors = 0;
  int thr    = 100;

  // model state: the image as the spec describes it
  int m_buf [MAXW];
  int m_ncol, m_width, m_left;
  bit m_first;

  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] obs_q[$];

  edge_grad #(.DW(DW), .MAXW(MAXW), .WW(WW)) dut (
    .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .ValidIn(ValidIn),
    .FrameIn(FrameIn), .LineIn(LineIn), .Width(Width), .Mode(Mode),
`ifdef EDGE_THRESH_EN
    .Thresh(Thresh),
`endif
    .PixelOut(PixelOut), .ValidOut(ValidOut), .FrameOut(FrameOut),
    .LineOut(LineOut)
  );

  always #5 Clk = ~Clk;

  // collect every valid output as {frame, line, pixel}
  always @(negedge Clk)
    if (ValidOut === 1'b1)
      obs_q.push_back({FrameOut, LineOut, PixelOut});

  function automatic logic [DW-1:0] exp_thr(int x);
    logic [DW-1:0] r;
`ifdef EDGE_THRESH_EN
    r = (x >= thr) ? '1 : '0;
`else
    r = x[DW-1:0];
`endif
    return r;
  endfunction

  function automatic int absdiff(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_reset;
    m_ncol  = 0;
    m_first = 1;
    m_width = MAXW;
  endtask

  task automatic model_pixel(int p, bit f, bit l, bit m, int w);
    int c, h, v, r;
    if (f) begin
      m_width = (w == 0) ? 1 : ((w > MAXW) ? MAXW : w);
      m_first = 1;
      c = 0;
    end else if (l) begin
      m_first = 0;
      c = 0;
    end else begin
      c = m_ncol;
    end
    h = (c == 0) ? 0 : absdiff(p, m_left);
    v = m_first ? 0 : absdiff(p, m_buf[c]);
    r = m ? ((h > v) ? h : v) : (h + v) / 2;
    exp_q.push_back({f, f | l, exp_thr(r)});
    m_buf[c] = p;
    m_left   = p;
    m_ncol   = (c + 1 < m_width) ? c + 1 : c;
  endtask

  // drive one cycle's inputs at a negedge, return at the next negedge
  task automatic send(int p, bit v, bit f, bit l, bit m, int w);
    PixelIn = p[DW-1:0];
    ValidIn = v;
    FrameIn = f;
    LineIn  = l;
    Mode    = m;
    Width   = w[WW-1:0];
    if (v && nReset)
      model_pixel(p, f, l, m, w);
    @(negedge Clk);
  endtask

  task automatic drain;
    repeat (6) send(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    int first_out;
    repeat (2) send(0, 0, 0, 0, 0, 4);
    checks++;
    if ({PixelOut, ValidOut, FrameOut, LineOut} !== '0) begin
      errors++;
      $display("FAIL reset_init got %h want 0", {PixelOut, ValidOut, FrameOut, LineOut});
    end
    nReset = 1'b1;
    model_reset();
    send(30, 1, 1, 0, 0, 4);
    send(40, 1, 0, 0, 0, 4);
    send(50, 1, 0, 0, 0, 4);
    nReset = 1'b0;
    repeat (2) send(0, 0, 0, 0, 0, 4);
    checks++;
    if ({PixelOut, ValidOut, FrameOut, LineOut} !== '0) begin
      errors++;
      $display("FAIL reset_mid got %h want 0", {PixelOut, ValidOut, FrameOut, LineOut});
    end
    obs_q.delete();
    exp_q.delete();
    model_reset();
    nReset = 1'b1;
    first_out = -1;
    for (int i = 0; i < 8; i++) begin
      send((i < 4) ? 50 + i * 10 : 0, i < 4, i == 0, 0, 0, 4);
      if (ValidOut === 1'b1 && first_out < 0)
        first_out = i + 1;
    end
    checks++;
    if (first_out != 3) begin
      errors++;
      $display("FAIL reset_latency got %0d want 3", first_out);
    end
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_flat;
    logic [DW+1:0] want;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++)
      send(100, 1, i == 0, (i % 4 == 0) && (i != 0), 0, 4);
    drain();
    checks++;
    if (obs_q.size() != 16) begin
      errors++;
      $display("FAIL flat_count got %0d want 16", obs_q.size());
    end
    for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
      want = {i == 0, i % 4 == 0, exp_thr(0)};
      checks++;
      if (obs_q[i] !== want) begin
        errors++;
        $display("FAIL flat_out[%0d] got %h want %h", i, obs_q[i], want);
      end
    end
  endtask

  task automatic test_step;
    int pix [4];
    int res [4];
    logic [DW+1:0] want;
    pix = '{0, 0, 200, 200};
    res = '{0, 0, 100, 0};
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++)
      send(pix[i % 4], 1, i == 0, i == 4, 0, 4);
    drain();
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL step_count got %0d want 8", obs_q.size());
    end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      want = {i == 0, i % 4 == 0, exp_thr(res[i % 4])};
      checks++;
      if (obs_q[i] !== want) begin
        errors++;
        $display("FAIL step_out[%0d] got %h want %h", i, obs_q[i], want);
      end
    end
  endtask

  task automatic test_vstep;
    logic [DW+1:0] want;
    int row1;
`ifdef EDGE_THRESH_EN
    for (int pass = 0; pass < 3; pass++) begin
      thr = (pass == 2) ? 241 : 100;
      Thresh = thr[DW-1:0];
`else
    for (int pass = 0; pass < 2; pass++) begin
`endif
      row1 = (pass == 1) ? 120 : 240;
      obs_q.delete();
      exp_q.delete();
      for (int i = 0; i < 6; i++)
        send((i < 3) ? 10 : 250, 1, i == 0, i == 3, pass != 1, 3);
      drain();
      checks++;
      if (obs_q.size() != 6) begin
        errors++;
        $display("FAIL vstep%0d_count got %0d want 6", pass, obs_q.size());
      end
      for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
        want = {i == 0, i % 3 == 0, exp_thr((i < 3) ? 0 : row1)};
        checks++;
        if (obs_q[i] !== want) begin
          errors++;
          $display("FAIL vstep%0d_out[%0d] got %h want %h", pass, i, obs_q[i], want);
        end
      end
    end
    thr = 100;
`ifdef EDGE_THRESH_EN
    Thresh = thr[DW-1:0];
`endif
  endtask

  task automatic test_gaps;
    int pix [4];
    int res [4];
    logic [DW+1:0] want;
    logic [DW-1:0] prev;
    int lows;
    pix = '{0, 0, 200, 200};
    res = '{0, 0, 100, 0};
    obs_q.delete();
    exp_q.delete();
    lows = 0;
    prev = PixelOut;
    for (int k = 0; k < 24; k++) begin
      if (k < 16 && k % 2 == 0)
        send(pix[(k / 2) % 4], 1, k == 0, k == 8, 0, 4);
      else
        send($urandom_range(0, 255), 0, 1, 1, 1, 0);
      if (ValidOut !== 1'b1) begin
        lows++;
        checks++;
        if (PixelOut !== prev || FrameOut !== 1'b0 || LineOut !== 1'b0) begin
          errors++;
          $display("FAIL gap_hold[%0d] got %h/%b/%b want %h/0/0", k, PixelOut, FrameOut, LineOut, prev);
        end
      end
      prev = PixelOut;
    end
    checks++;
    if (lows < 8) begin
      errors++;
      $display("FAIL gap_lows got %0d want >=8", lows);
    end
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL gap_count got %0d want 8", obs_q.size());
    end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      want = {i == 0, i % 4 == 0, exp_thr(res[i % 4])};
      checks++;
      if (obs_q[i] !== want) begin
        errors++;
        $display("FAIL gap_out[%0d] got %h want %h", i, obs_q[i], want);
      end
    end
  endtask

  task automatic test_back_to_back;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++)
      send($urandom_range(0, 255), 1, i == 0, i == 3, $urandom_range(0, 1), 3);
    for (int i = 0; i < 5; i++)
      send($urandom_range(0, 255), 1, i == 0, 0, $urandom_range(0, 1), 0);
    for (int i = 0; i < 3; i++)
      send($urandom_range(0, 255), 1, 0, i == 0, $urandom_range(0, 1), 7);
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic send_gappy(int p, bit f, bit l, int w);
    if ($urandom_range(0, 3) == 0)
      send($urandom_range(0, 255), 0, $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 511));
    send(p, 1, f, l, $urandom_range(0, 1), w);
  endtask

  task automatic test_random;
    int w, len;
    obs_q.delete();
    exp_q.delete();
    for (int fr = 0; fr < 6; fr++) begin
      w = $urandom_range(1, 8);
      len = w + $urandom_range(0, 2);
      for (int i = 0; i < len; i++)
        send_gappy($urandom_range(0, 255), i == 0, 0, w);
      for (int r = 0; r < 3; r++) begin
        len = $urandom_range(1, w + 2);
        for (int i = 0; i < len; i++)
          send_gappy($urandom_range(0, 255), 0, i == 0, $urandom_range(0, 511));
      end
    end
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    nReset  = 1'b0;
    PixelIn = '0;
    ValidIn = 1'b0;
    FrameIn = 1'b0;
    LineIn  = 1'b0;
    Mode    = 1'b0;
    Width   = '0;
`ifdef EDGE_THRESH_EN
    Thresh  = thr[DW-1:0];
`endif
    for (int i = 0; i < MAXW; i++)
      m_buf[i] = 0;
    model_reset();
    @(negedge Clk);
    test_reset();
    test_flat();
    test_step();
    test_vstep();
    test_gaps();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
